// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core sizing constants and id typedefs
package mips_core_pkg;

  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int NUM_CKPT = 4;

  localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int PREG_W   = $clog2(NUM_PHYS);
  localparam int CKPT_W   = $clog2(NUM_CKPT);
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [CKPT_W-1:0]   ckpt_id_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [NUM_CKPT-1:0] ckpt_mask_t;

endpackage

// File: rtl/phys_free_list_if.sv
// rtl/phys_free_list_if.sv - rename/commit/branch port bundle of the free list
interface phys_free_list_if;
  import mips_core_pkg::*;

  logic       alloc_req;
  logic       alloc_ready;
  preg_t      alloc_preg;
  logic       release_valid;
  preg_t      release_preg;
  logic       ckpt_req;
  ckpt_id_t   ckpt_id;
  logic       ckpt_full;
  logic       ckpt_free_valid;
  ckpt_id_t   ckpt_free_id;
  logic       restore_valid;
  ckpt_id_t   restore_id;
  ckpt_mask_t restore_kill_mask;
  fl_ptr_t    free_count;
  logic       overflow_err;

  modport master (
    output alloc_req, release_valid, release_preg, ckpt_req,
           ckpt_free_valid, ckpt_free_id, restore_valid, restore_id, restore_kill_mask,
    input  alloc_ready, alloc_preg, ckpt_id, ckpt_full, free_count, overflow_err
  );

  modport slave (
    input  alloc_req, release_valid, release_preg, ckpt_req,
           ckpt_free_valid, ckpt_free_id, restore_valid, restore_id, restore_kill_mask,
    output alloc_ready, alloc_preg, ckpt_id, ckpt_full, free_count, overflow_err
  );

endinterface

// File: rtl/free_list_ckpt_table.sv
// rtl/free_list_ckpt_table.sv - branch checkpoint slots holding saved free-list heads
module free_list_ckpt_table
  import mips_core_pkg::*;
#(
  parameter int NUM_SLOTS = mips_core_pkg::NUM_CKPT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       save_en,
  input  fl_ptr_t    save_head,
  input  logic       free_en,
  input  ckpt_id_t   free_id,
  input  logic       restore_en,
  input  ckpt_id_t   restore_id,
  input  ckpt_mask_t kill_mask,
  output ckpt_id_t   free_slot,
  output logic       full,
  output logic       restore_hit,
  output fl_ptr_t    restore_head
);

  ckpt_mask_t valid;
  ckpt_mask_t valid_next;
  fl_ptr_t    heads [NUM_SLOTS];
  logic       save_fire;

  // Scan downward so the lowest-index free slot wins.
  always_comb begin
    free_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) free_slot = ckpt_id_t'(i);
    end
  end

  assign full         = &valid;
  assign save_fire    = save_en && !full;
  assign restore_hit  = valid[restore_id];
  assign restore_head = heads[restore_id];

  // Clears first, then the save, so a new snapshot is never wiped in its own cycle.
  always_comb begin
    valid_next = valid;
    if (free_en)    valid_next[free_id] = 1'b0;
    if (restore_en) valid_next = valid_next & ~kill_mask;
    if (save_fire)  valid_next[free_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      valid <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && save_fire) begin
      heads[free_slot] <= save_head;
    end
  end

endmodule

// File: rtl/phys_free_list.sv
// rtl/phys_free_list.sv - circular free list of physical register ids with branch rollback
module phys_free_list
  import mips_core_pkg::*;
#(
  parameter int NUM_PHYS = mips_core_pkg::NUM_PHYS,
  parameter int NUM_ARCH = mips_core_pkg::NUM_ARCH,
  parameter int NUM_CKPT = mips_core_pkg::NUM_CKPT
) (
  input  logic             clk,
  input  logic             rst,
  phys_free_list_if.slave  fl
);

  localparam int DEPTH = NUM_PHYS - NUM_ARCH;

  fl_ptr_t head;
  fl_ptr_t tail;
  fl_ptr_t head_post;
  fl_ptr_t head_next;
  fl_ptr_t tail_next;
  fl_ptr_t count;
  preg_t   fifo [DEPTH];

  logic    full;
  logic    alloc_fire;
  logic    release_fire;
  logic    restore_hit;
  fl_ptr_t restore_head;

  // Wrap bit makes tail - head the exact occupancy, 0..DEPTH.
  assign count        = tail - head;
  assign full         = (count == fl_ptr_t'(DEPTH));

  assign fl.alloc_ready  = (count != '0);
  assign fl.alloc_preg   = fifo[head[FL_IDX_W-1:0]];
  assign fl.free_count   = count;

  assign alloc_fire   = fl.alloc_req && fl.alloc_ready && !fl.restore_valid;
  assign release_fire = fl.release_valid && !full;

  assign head_post = head + {{(FL_PTR_W-1){1'b0}}, alloc_fire};
  assign tail_next = tail + {{(FL_PTR_W-1){1'b0}}, release_fire};

  always_comb begin
    head_next = head_post;
    if (fl.restore_valid) begin
      head_next = restore_hit ? restore_head : head;
    end
  end

  free_list_ckpt_table #(
    .NUM_SLOTS (NUM_CKPT)
  ) u_ckpt (
    .clk          (clk),
    .rst          (rst),
    .save_en      (fl.ckpt_req && !fl.restore_valid),
    .save_head    (head_post),
    .free_en      (fl.ckpt_free_valid),
    .free_id      (fl.ckpt_free_id),
    .restore_en   (fl.restore_valid),
    .restore_id   (fl.restore_id),
    .kill_mask    (fl.restore_kill_mask),
    .free_slot    (fl.ckpt_id),
    .full         (fl.ckpt_full),
    .restore_hit  (restore_hit),
    .restore_head (restore_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= fl_ptr_t'(DEPTH);
      fl.overflow_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= preg_t'(NUM_ARCH + i);
      end
    end else begin
      head <= head_next;
      tail <= tail_next;
      if (release_fire) begin
        fifo[tail[FL_IDX_W-1:0]] <= fl.release_preg;
      end
      if (fl.release_valid && full) begin
        fl.overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// tb/tb_phys_free_list.sv - scoreboard bench for phys_free_list
module tb_phys_free_list;
  import mips_core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  phys_free_list_if bus ();

  phys_free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  int    total = 0;
  int    bad   = 0;
  preg_t exp_q [$];
  preg_t e;
  preg_t r;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req         = 1'b0;
    bus.release_valid     = 1'b0;
    bus.release_preg      = '0;
    bus.ckpt_req          = 1'b0;
    bus.ckpt_free_valid   = 1'b0;
    bus.ckpt_free_id      = '0;
    bus.restore_valid     = 1'b0;
    bus.restore_id        = '0;
    bus.restore_kill_mask = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(preg_t'(32 + i));
  endtask

  task automatic test_reset();
    idle();
    bus.alloc_req = 1'b1;
    bus.release_valid = 1'b1;
    bus.ckpt_req = 1'b1;
    rst = 1'b1;
    cyc();
    do_reset();
    total++; if (bus.alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", bus.alloc_ready); end
    total++; if (bus.alloc_preg !== preg_t'(32)) begin bad++; $display("FAIL reset_preg got=%0d exp=32", bus.alloc_preg); end
    total++; if (bus.free_count !== fl_ptr_t'(32)) begin bad++; $display("FAIL reset_count got=%0d exp=32", bus.free_count); end
    total++; if (bus.ckpt_id !== ckpt_id_t'(0)) begin bad++; $display("FAIL reset_ckpt_id got=%0d exp=0", bus.ckpt_id); end
    total++; if (bus.ckpt_full !== 1'b0) begin bad++; $display("FAIL reset_ckpt_full got=%0b exp=0", bus.ckpt_full); end
    total++; if (bus.overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow_err); end
  endtask

  task automatic test_alloc_all();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      total++;
      if (bus.alloc_ready !== 1'b1 || bus.alloc_preg !== e) begin
        bad++; $display("FAIL alloc_seq i=%0d got ready=%0b id=%0d exp ready=1 id=%0d", i, bus.alloc_ready, bus.alloc_preg, e);
      end
      bus.alloc_req = 1'b1;
      cyc();
    end
    bus.alloc_req = 1'b0;
    total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL empty_ready got=%0b exp=0", bus.alloc_ready); end
    total++; if (bus.free_count !== fl_ptr_t'(0)) begin bad++; $display("FAIL empty_count got=%0d exp=0", bus.free_count); end
    bus.alloc_req = 1'b1;
    cyc();
    bus.alloc_req = 1'b0;
    total++; if (bus.free_count !== fl_ptr_t'(0)) begin bad++; $display("FAIL alloc33_count got=%0d exp=0", bus.free_count); end
    bus.release_valid = 1'b1;
    bus.release_preg = preg_t'(7);
    cyc();
    idle();
    total++; if (bus.alloc_preg !== preg_t'(7) || bus.free_count !== fl_ptr_t'(1)) begin
      bad++; $display("FAIL alloc33_head got id=%0d count=%0d exp id=7 count=1", bus.alloc_preg, bus.free_count);
    end
  endtask

  task automatic test_empty_release();
    do_reset();
    for (int i = 0; i < 32; i++) begin bus.alloc_req = 1'b1; cyc(); end
    bus.alloc_req = 1'b1;
    bus.release_valid = 1'b1;
    bus.release_preg = preg_t'(5);
    total++; if (bus.alloc_ready !== 1'b0) begin bad++; $display("FAIL bypass_ready got=%0b exp=0", bus.alloc_ready); end
    cyc();
    idle();
    total++; if (bus.alloc_ready !== 1'b1 || bus.alloc_preg !== preg_t'(5) || bus.free_count !== fl_ptr_t'(1)) begin
      bad++; $display("FAIL bypass_next got ready=%0b id=%0d count=%0d exp ready=1 id=5 count=1", bus.alloc_ready, bus.alloc_preg, bus.free_count);
    end
  endtask

  task automatic test_ckpt_restore();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      total++; if (bus.alloc_preg !== e) begin bad++; $display("FAIL pre_ckpt_id got=%0d exp=%0d", bus.alloc_preg, e); end
      bus.alloc_req = 1'b1; cyc();
    end
    idle();
    total++; if (bus.ckpt_id !== ckpt_id_t'(0)) begin bad++; $display("FAIL ckpt_slot got=%0d exp=0", bus.ckpt_id); end
    bus.ckpt_req = 1'b1; cyc(); idle();
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      total++; if (bus.alloc_preg !== e) begin bad++; $display("FAIL post_ckpt_id got=%0d exp=%0d", bus.alloc_preg, e); end
      bus.alloc_req = 1'b1; cyc();
    end
    idle();
    bus.release_valid = 1'b1; bus.release_preg = preg_t'(1); cyc();
    bus.release_preg = preg_t'(2);
    bus.restore_valid = 1'b1; bus.restore_id = ckpt_id_t'(0); bus.restore_kill_mask = 4'b0001;
    bus.alloc_req = 1'b1;
    cyc(); idle();
    total++; if (bus.free_count !== fl_ptr_t'(31)) begin bad++; $display("FAIL restore_count got=%0d exp=31", bus.free_count); end
    total++; if (bus.alloc_preg !== preg_t'(35)) begin bad++; $display("FAIL restore_head got=%0d exp=35", bus.alloc_preg); end
    total++; if (bus.ckpt_id !== ckpt_id_t'(0)) begin bad++; $display("FAIL restore_kill got=%0d exp=0", bus.ckpt_id); end
  endtask

  task automatic test_ckpt_same_cycle();
    do_reset();
    for (int i = 0; i < 2; i++) begin bus.alloc_req = 1'b1; cyc(); end
    bus.ckpt_req = 1'b1; cyc(); idle();
    for (int i = 0; i < 2; i++) begin bus.alloc_req = 1'b1; cyc(); end
    idle();
    bus.restore_valid = 1'b1; bus.restore_id = ckpt_id_t'(0); bus.restore_kill_mask = 4'b0001;
    cyc(); idle();
    total++; if (bus.alloc_preg !== preg_t'(35) || bus.free_count !== fl_ptr_t'(29)) begin
      bad++; $display("FAIL ckpt_post_alloc got id=%0d count=%0d exp id=35 count=29", bus.alloc_preg, bus.free_count);
    end
    bus.ckpt_req = 1'b1; cyc(); idle();
    bus.restore_valid = 1'b1; bus.restore_id = ckpt_id_t'(1); bus.restore_kill_mask = 4'b0001;
    bus.alloc_req = 1'b1; bus.ckpt_req = 1'b1;
    cyc(); idle();
    total++; if (bus.alloc_preg !== preg_t'(35) || bus.free_count !== fl_ptr_t'(29)) begin
      bad++; $display("FAIL restore_invalid got id=%0d count=%0d exp id=35 count=29", bus.alloc_preg, bus.free_count);
    end
    total++; if (bus.ckpt_id !== ckpt_id_t'(0) || bus.ckpt_full !== 1'b0) begin
      bad++; $display("FAIL restore_invalid_kill got id=%0d full=%0b exp id=0 full=0", bus.ckpt_id, bus.ckpt_full);
    end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ckpt_id !== ckpt_id_t'(i) || bus.ckpt_full !== 1'b0) begin
        bad++; $display("FAIL ckpt_fill i=%0d got id=%0d full=%0b exp id=%0d full=0", i, bus.ckpt_id, bus.ckpt_full, i);
      end
      bus.ckpt_req = 1'b1; cyc();
    end
    idle();
    total++; if (bus.ckpt_full !== 1'b1) begin bad++; $display("FAIL ckpt_full got=%0b exp=1", bus.ckpt_full); end
    bus.ckpt_req = 1'b1; cyc(); idle();
    total++; if (bus.ckpt_full !== 1'b1) begin bad++; $display("FAIL ckpt_fifth got=%0b exp=1", bus.ckpt_full); end
    bus.ckpt_free_valid = 1'b1; bus.ckpt_free_id = ckpt_id_t'(2); cyc(); idle();
    total++; if (bus.ckpt_id !== ckpt_id_t'(2) || bus.ckpt_full !== 1'b0) begin
      bad++; $display("FAIL ckpt_free got id=%0d full=%0b exp id=2 full=0", bus.ckpt_id, bus.ckpt_full);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.release_valid = 1'b1; bus.release_preg = preg_t'(9); cyc(); idle();
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_set got=%0b exp=1", bus.overflow_err); end
    total++; if (bus.free_count !== fl_ptr_t'(32) || bus.alloc_preg !== preg_t'(32)) begin
      bad++; $display("FAIL overflow_tail got count=%0d id=%0d exp count=32 id=32", bus.free_count, bus.alloc_preg);
    end
    bus.alloc_req = 1'b1; cyc(); idle(); cyc();
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL overflow_sticky got=%0b exp=1", bus.overflow_err); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    e = exp_q.pop_front();
    bus.alloc_req = 1'b1; cyc(); idle();
    for (int i = 0; i < 100; i++) begin
      e = exp_q.pop_front();
      total++; if (bus.alloc_preg !== e || bus.free_count !== fl_ptr_t'(31)) begin
        bad++; $display("FAIL wrap i=%0d got id=%0d count=%0d exp id=%0d count=31", i, bus.alloc_preg, bus.free_count, e);
      end
      r = preg_t'($urandom_range(0, 63));
      exp_q.push_back(r);
      bus.alloc_req = 1'b1; bus.release_valid = 1'b1; bus.release_preg = r;
      cyc();
    end
    idle();
    total++; if (bus.free_count !== fl_ptr_t'(31) || bus.overflow_err !== 1'b0) begin
      bad++; $display("FAIL wrap_end got count=%0d ovf=%0b exp count=31 ovf=0", bus.free_count, bus.overflow_err);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_alloc_all();
    test_empty_release();
    test_ckpt_restore();
    test_ckpt_same_cycle();
    test_ckpt_full();
    test_overflow();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS, default 64, meaning the total number of physical registers.
REQ-002 SHALL have parameter NUM_ARCH, default 32, meaning the number of architectural registers; free-list depth FL_DEPTH = NUM_PHYS-NUM_ARCH (32).
REQ-003 SHALL have parameter NUM_CKPT, default 4, meaning the number of branch checkpoints.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its posedge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port alloc_req  in  1  rename requests one physical register this cycle.
REQ-007 SHALL have port alloc_ready  out  1  a free register is available (free_count != 0).
REQ-008 SHALL have port alloc_preg  out  log2(NUM_PHYS)  register id at the head; valid when alloc_ready.
REQ-009 SHALL have port release_valid  in  1  commit returns one register.
REQ-010 SHALL have port release_preg  in  log2(NUM_PHYS)  register id being returned.
REQ-011 SHALL have port ckpt_req  in  1  a branch is being renamed; snapshot the head.
REQ-012 SHALL have port ckpt_id  out  log2(NUM_CKPT)  lowest-index free checkpoint slot; the slot used on ckpt_req.
REQ-013 SHALL have port ckpt_full  out  1  all checkpoint slots valid; rename stalls branches.
REQ-014 SHALL have port ckpt_free_valid, ckpt_free_id  in  1, log2(NUM_CKPT)  a branch committed; release its slot.
REQ-015 SHALL have port restore_valid, restore_id  in  1, log2(NUM_CKPT)  branch_miss; roll back the head to slot restore_id.
REQ-016 SHALL have port restore_kill_mask  in  NUM_CKPT  slots (including restore_id) invalidated on restore.
REQ-017 SHALL have port free_count  out  log2(FL_DEPTH)+1  number of free registers held.
REQ-018 SHALL have port overflow_err  out  1  sticky error flag: a release arrived while the list was full.

Function
REQ-019 SHALL store free ids in a circular FIFO of FL_DEPTH entries, with head/tail pointers of log2(FL_DEPTH)+1 bits (the MSB is the wrap bit).
REQ-020 SHALL compute free_count = tail - head (modulo 2^(log2(FL_DEPTH)+1)); full when free_count == FL_DEPTH.
REQ-021 SHALL drive alloc_preg and alloc_ready combinationally from the current head and count, with zero-latency grant.
REQ-022 SHALL, on alloc_req && alloc_ready, advance the head by 1 at the clock edge.
REQ-023 SHALL ignore alloc_req when alloc_ready is 0, with no bypass of a same-cycle release.
REQ-024 SHALL, on release_valid, write release_preg at the tail and advance the tail by 1.
REQ-025 SHALL, on release_valid while full, drop the write, leave the tail unchanged, and set overflow_err until reset.
REQ-026 SHALL, on simultaneous alloc and release, perform both and leave free_count unchanged.
REQ-027 SHALL, on ckpt_req && !ckpt_full, store the post-allocation head (head plus any same-cycle granted alloc) into slot ckpt_id and set its valid bit.
REQ-028 SHALL ignore ckpt_req when ckpt_full is 1.
REQ-029 SHALL, on ckpt_free_valid, clear valid[ckpt_free_id].
REQ-030 SHALL, on restore_valid, load the head from slot[restore_id], clear valid for every set bit of restore_kill_mask, and ignore same-cycle alloc_req and ckpt_req.
REQ-031 SHALL still apply release_valid and ckpt_free_valid during a restore cycle; free_count afterwards equals tail_next - restored head.
REQ-032 SHALL, if restore_valid targets an invalid slot, leave the head unchanged (kill mask still applied).
REQ-033 SHALL wrap both pointers naturally at FL_DEPTH with no special casing.

Reset
REQ-034 SHALL, while rst is high at a clock edge: set head=0, tail=FL_DEPTH (wrap bit 1, index 0), fifo[i]=NUM_ARCH+i, all checkpoint valid bits=0, overflow_err=0.
REQ-035 SHALL, after reset, present outputs alloc_ready=1, alloc_preg=NUM_ARCH, free_count=FL_DEPTH, ckpt_id=0, ckpt_full=0.
REQ-036 SHALL let reset override every concurrent request, including mid-restore.

Structure
REQ-037 SHALL take NUM_PHYS, NUM_ARCH, NUM_CKPT and the preg_t/ckpt_id_t typedefs from the shared mips_core_pkg.
REQ-038 SHALL place the checkpoint storage (valid bits, saved heads, lowest-free encoder) in the sub-module free_list_ckpt_table.

Verification
REQ-039 SHALL cover: reset, then 32 consecutive allocs -> ids 32..63 in order, alloc_ready=0 after the 32nd, and a 33rd alloc ignored.
REQ-040 SHALL cover: empty list with same-cycle alloc_req and release_preg=5 -> no grant that cycle; next cycle alloc_preg=5.
REQ-041 SHALL cover: 3 allocs, ckpt_req (ckpt_id=0), 4 allocs, 2 releases, restore id 0 -> head back to 3, free_count=31.
REQ-042 SHALL cover: 4 ckpt_req -> ckpt_full=1 and a 5th ignored; ckpt_free id 2 -> ckpt_id=2, ckpt_full=0.
REQ-043 SHALL cover: on a full list, a release -> overflow_err=1 and sticky, with the tail unchanged.
REQ-044 SHALL cover: 100 alloc/release pairs across pointer wrap -> free_count constant and ids returned in FIFO order.
